alu_issue_ctrl: RTL and testbench

- Issue-side controller for the team's registered ALU.
- Accepts decoded ALU operations over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU request interface (enable, func, a, b, imm), waits for the ALU's completion strobe, and writes the result back to the register file.
- Sits between the instruction decoder and the ALU; executes strictly one operation at a time.

---
 rtl/alu_issue_ctrl_pkg.sv | 24 ++
 rtl/alu_issue_ctrl_regfile.sv | 39 +++
 rtl/alu_issue_ctrl.sv | 167 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALU function codes
// (common with the ALU itself), controller FSM states and the
// reserved-function check.
package alu_issue_ctrl_pkg;

    localparam logic [2:0] FUNC_ADD  = 3'd0;
    localparam logic [2:0] FUNC_SUB  = 3'd1;
    localparam logic [2:0] FUNC_ADDI = 3'd2;
    localparam logic [2:0] FUNC_AND  = 3'd3;
    localparam logic [2:0] FUNC_ANDI = 3'd4;
    localparam logic [2:0] FUNC_OR   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Codes 6 and 7 have no ALU operation behind them.
    function automatic logic func_reserved(input logic [2:0] func);
        return (func == 3'd6) || (func == 3'd7);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Register file for the ALU issue controller: NREGS x DWIDTH, two
// combinational operand read ports, one combinational debug read port and
// one synchronous write port. Register 0 always reads as zero.
module alu_regfile #(
    parameter int DWIDTH = 16,
    parameter int NREGS  = 8,
    parameter int AWIDTH = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] rs1_addr,
    output logic [DWIDTH-1:0] rs1_data,
    input  logic [AWIDTH-1:0] rs2_addr,
    output logic [DWIDTH-1:0] rs2_data,
    input  logic [AWIDTH-1:0] dbg_addr,
    output logic [DWIDTH-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data
);

    logic [DWIDTH-1:0] regs [NREGS];

    // Clear everything on reset; writes to index 0 are dropped so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for the registered ALU. Accepts one decoded
// operation at a time, reads operands from the local register file at
// accept, strobes the ALU once, waits for its completion strobe and writes
// the result back.
// Optional build macro ALU_TIMEOUT_EN: abort a WAIT that lasts TIMEOUT
// cycles without alu_done, pulsing err_timeout and skipping the write.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int NREGS   = 8,
    parameter int AWIDTH  = $clog2(NREGS),
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_func,
    input  logic [AWIDTH-1:0] in_rd,
    input  logic [AWIDTH-1:0] in_rs1,
    input  logic [AWIDTH-1:0] in_rs2,
    input  logic [DWIDTH-1:0] in_imm,
    output logic              alu_en,
    output logic [2:0]        alu_func,
    output logic [DWIDTH-1:0] alu_a,
    output logic [DWIDTH-1:0] alu_b,
    output logic [DWIDTH-1:0] alu_imm,
    input  logic [DWIDTH-1:0] alu_res,
    input  logic              alu_done,
    output logic              wb_valid,
    output logic [AWIDTH-1:0] wb_rd,
    output logic [DWIDTH-1:0] wb_data,
    output logic              err_illegal,
    output logic              err_timeout,
    input  logic [AWIDTH-1:0] dbg_addr,
    output logic [DWIDTH-1:0] dbg_data
);

    state_t            state_q, state_d;
    logic              accept, reject, wb_we;
    logic [AWIDTH-1:0] rd_q;
    logic [DWIDTH-1:0] rs1_data, rs2_data;

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             tmo;
`endif

    alu_regfile #(
        .DWIDTH (DWIDTH),
        .NREGS  (NREGS),
        .AWIDTH (AWIDTH)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (in_rs1),
        .rs1_data (rs1_data),
        .rs2_addr (in_rs2),
        .rs2_data (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_en    (wb_we),
        .wr_addr  (rd_q),
        .wr_data  (alu_res)
    );

    assign in_ready = (state_q == ST_IDLE);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus accept/reject/writeback decisions for this cycle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        wb_we   = 1'b0;
`ifdef ALU_TIMEOUT_EN
        tmo     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (func_reserved(in_func)) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (alu_done) begin
                    wb_we   = 1'b1;
                    state_d = ST_IDLE;
                end
`ifdef ALU_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    tmo     = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered ALU request, writeback report and illegal-func strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_en      <= 1'b0;
            alu_func    <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_imm     <= '0;
            rd_q        <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            err_illegal <= 1'b0;
        end else begin
            alu_en      <= accept;
            wb_valid    <= wb_we;
            err_illegal <= reject;
            if (accept) begin
                alu_func <= in_func;
                alu_a    <= rs1_data;
                alu_b    <= rs2_data;
                alu_imm  <= in_imm;
                rd_q     <= in_rd;
            end
            if (wb_we) begin
                wb_rd   <= rd_q;
                wb_data <= alu_res;
            end
        end
    end

`ifdef ALU_TIMEOUT_EN
    // Count WAIT cycles; the count restarts whenever the FSM leaves WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= tmo;
            if (state_q == ST_WAIT && state_d == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a registered ALU stub.
module tb_alu_issue_ctrl;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_func = '0;
    logic [AW-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [DW-1:0] in_imm = '0;
    logic          alu_en;
    logic [2:0]    alu_func;
    logic [DW-1:0] alu_a, alu_b, alu_imm, alu_res;
    logic          alu_done;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          err_illegal, err_timeout;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_data;

    logic          stub_on = 1'b1;
    logic          force_done = 1'b0;
    logic [DW-1:0] force_res = '0;
    logic          done_q;
    logic [DW-1:0] res_q;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_func     (in_func),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .alu_en      (alu_en),
        .alu_func    (alu_func),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_imm     (alu_imm),
        .alu_res     (alu_res),
        .alu_done    (alu_done),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Registered ALU stub: result and done strobe one cycle after alu_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            res_q  <= '0;
        end else begin
            done_q <= alu_en & stub_on;
            if (alu_en) begin
                case (alu_func)
                    3'd0:    res_q <= alu_a + alu_b;
                    3'd1:    res_q <= alu_a - alu_b;
                    3'd2:    res_q <= alu_a + alu_imm;
                    3'd3:    res_q <= alu_a & alu_b;
                    3'd4:    res_q <= alu_a & alu_imm;
                    3'd5:    res_q <= alu_a | alu_b;
                    default: res_q <= '0;
                endcase
            end
        end
    end

    assign alu_done = done_q | force_done;
    assign alu_res  = force_done ? force_res : res_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [AW-1:0] idx, input logic [DW-1:0] exp);
        dbg_addr = idx;
        #1;
        chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    // Offer one op in the current (IDLE) cycle and follow it to writeback at T+3.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [AW-1:0] rd,
                          input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [DW-1:0] imm, input logic [DW-1:0] exp_a,
                          input logic [DW-1:0] exp_b, input logic [DW-1:0] exp_wb);
        in_func = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        chk({tag, ".rdy0"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk({tag, ".en1"}, 32'(alu_en), 32'd1);
        chk({tag, ".a"}, 32'(alu_a), 32'(exp_a));
        chk({tag, ".b"}, 32'(alu_b), 32'(exp_b));
        chk({tag, ".func"}, 32'(alu_func), 32'(f));
        tick();
        chk({tag, ".en2"}, 32'(alu_en), 32'd0);
        chk({tag, ".wbv2"}, 32'(wb_valid), 32'd0);
        tick();
        chk({tag, ".wbv3"}, 32'(wb_valid), 32'd1);
        chk({tag, ".wbrd"}, 32'(wb_rd), 32'(rd));
        chk({tag, ".wbd"}, 32'(wb_data), 32'(exp_wb));
        chk({tag, ".rdy3"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        tick(); tick();
        rst = 1'b0;
        chk("rst.rdy", 32'(in_ready), 32'd1);
        chk("rst.en", 32'(alu_en), 32'd0);
        chk("rst.wbv", 32'(wb_valid), 32'd0);
        chk("rst.ill", 32'(err_illegal), 32'd0);
        chk("rst.a", 32'(alu_a), 32'd0);
        for (int i = 0; i < 8; i++) chk_reg($sformatf("rst.r%0d", i), AW'(i), 16'h0000);

        // Preload and SUB
        run_op("addi1", 3'd2, 3'd1, 3'd0, 3'd0, 16'h0005, 16'h0000, 16'h0000, 16'h0005);
        run_op("addi2", 3'd2, 3'd2, 3'd0, 3'd0, 16'h0003, 16'h0000, 16'h0000, 16'h0003);
        run_op("sub",   3'd1, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h0005, 16'h0003, 16'h0002);
        chk_reg("sub.r3", 3'd3, 16'h0002);

        // Back-to-back with in_valid held: ADD r4=r3+r3 then OR r5=r4|r1
        in_func = 3'd0; in_rd = 3'd4; in_rs1 = 3'd3; in_rs2 = 3'd3; in_imm = '0;
        in_valid = 1'b1;
        tick();
        in_func = 3'd5; in_rd = 3'd5; in_rs1 = 3'd4; in_rs2 = 3'd1;
        chk("b2b.en1", 32'(alu_en), 32'd1);
        chk("b2b.rdy1", 32'(in_ready), 32'd0);
        tick();
        chk("b2b.rdy2", 32'(in_ready), 32'd0);
        tick();
        chk("b2b.rdy3", 32'(in_ready), 32'd1);
        chk("b2b.wbd1", 32'(wb_data), 32'h0004);
        tick();
        in_valid = 1'b0;
        chk("b2b.en4", 32'(alu_en), 32'd1);
        chk("b2b.a4", 32'(alu_a), 32'h0004);
        chk("b2b.b4", 32'(alu_b), 32'h0005);
        tick(); tick();
        chk("b2b.wbv6", 32'(wb_valid), 32'd1);
        chk("b2b.wbrd6", 32'(wb_rd), 32'd5);
        chk("b2b.wbd6", 32'(wb_data), 32'h0005);
        chk_reg("b2b.r4", 3'd4, 16'h0004);
        chk_reg("b2b.r5", 3'd5, 16'h0005);

        // Reserved func
        in_func = 3'd7; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ill.pulse", 32'(err_illegal), 32'd1);
        chk("ill.en", 32'(alu_en), 32'd0);
        chk("ill.rdy", 32'(in_ready), 32'd1);
        tick();
        chk("ill.off", 32'(err_illegal), 32'd0);
        chk("ill.en2", 32'(alu_en), 32'd0);
        chk_reg("ill.r3", 3'd3, 16'h0002);

        // Write to r0 reports but does not stick
        run_op("r0", 3'd2, 3'd0, 3'd0, 3'd0, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF);
        chk_reg("r0.keep", 3'd0, 16'h0000);
        tick();
        chk("r0.wboff", 32'(wb_valid), 32'd0);

        // Stray alu_done while IDLE
        force_done = 1'b1; force_res = 16'h1234;
        tick();
        force_done = 1'b0;
        tick();
        chk("idle_done.wbv", 32'(wb_valid), 32'd0);
        chk("idle_done.wbd", 32'(wb_data), 32'hFFFF);
        chk("idle_done.rdy", 32'(in_ready), 32'd1);

        // ALU never answers
        stub_on = 1'b0;
        in_func = 3'd0; in_rd = 3'd6; in_rs1 = 3'd1; in_rs2 = 3'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("hang.en", 32'(alu_en), 32'd1);
`ifdef ALU_TIMEOUT_EN
        for (int k = 2; k <= 16; k++) tick();
        chk("tmo.before", 32'(err_timeout), 32'd0);
        chk("tmo.rdy_before", 32'(in_ready), 32'd0);
        tick();
        chk("tmo.pulse", 32'(err_timeout), 32'd1);
        chk("tmo.rdy", 32'(in_ready), 32'd1);
        chk("tmo.wbv", 32'(wb_valid), 32'd0);
        tick();
        chk("tmo.off", 32'(err_timeout), 32'd0);
        chk_reg("tmo.r6", 3'd6, 16'h0000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("hang2.en", 32'(alu_en), 32'd1);
`else
        for (int k = 2; k <= 20; k++) tick();
        chk("hang.rdy", 32'(in_ready), 32'd0);
        chk("hang.tmo", 32'(err_timeout), 32'd0);
`endif
        tick(); tick();
        chk("rstw.rdy_before", 32'(in_ready), 32'd0);

        // Reset during WAIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stub_on = 1'b1;
        chk("rstw.rdy", 32'(in_ready), 32'd1);
        chk("rstw.wbv", 32'(wb_valid), 32'd0);
        chk("rstw.a", 32'(alu_a), 32'd0);
        chk_reg("rstw.r6", 3'd6, 16'h0000);
        chk_reg("rstw.r1", 3'd1, 16'h0000);
        tick();
        chk("rstw.wbv2", 32'(wb_valid), 32'd0);
        chk("rstw.en2", 32'(alu_en), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
